hilo_acc: RTL and testbench
===========================

Name: hilo_acc

Overview:
- Parametrised HI/LO special-register block for the execute/write-back boundary.
- Holds the HI and LO registers.
- Supports independent HI-only, LO-only and joint writes (MTHI/MTLO/MULT/DIV results).
- Supports MADD/MSUB-style accumulation of a 2*DATA_W operand into {HI,LO}, optionally split over two cycles to shorten the carry path.
- Ready/valid and flush handshake with the pipeline controller.

Parameters:
- DATA_W, 32, width of each of HI and LO.
- PIPE_ACC, 1, 1 = two-cycle accumulate (low half, then high half with carry); 0 = single-cycle accumulate.

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  synchronous reset, active-high
- valid_i  input  1  request valid
- op_i  input  3  0 NOP, 1 WR_HI, 2 WR_LO, 3 WR_BOTH, 4 MADD, 5 MSUB, 6-7 treated as NOP
- hi_in  input  DATA_W  HI write data / accumulate operand upper half
- lo_in  input  DATA_W  LO write data / accumulate operand lower half
- flush_i  input  1  abort in-flight accumulate (exception/branch squash)
- ready_o  output  1  block can accept a request this cycle
- busy_o  output  1  accumulate in flight
- done_o  output  1  one-cycle pulse on the cycle after any committed update
- hi_o  output  DATA_W  architectural HI
- lo_o  output  DATA_W  architectural LO

Behaviour:
- Reset (rst=1 at posedge): hi_o=0, lo_o=0, done_o=0, state=IDLE, staging registers cleared. Reset overrides every other input, including mid-accumulate.
- Accept: a request is accepted when valid_i & ready_o at posedge.
- ready_o = (state==IDLE) & ~flush_i, combinational.
- busy_o = (state!=IDLE).
- WR_HI: updates only hi_o at the accept edge; lo_o holds.
- WR_LO: updates only lo_o at the accept edge; hi_o holds.
- WR_BOTH: updates both at the accept edge.
- Write latency: result visible the cycle after the accept edge; done_o=1 that cycle.
- MADD: {hi_o,lo_o} <= {hi_o,lo_o} + {hi_in,lo_in}, modulo 2^(2*DATA_W). No overflow flag, no trap.
- MSUB: {hi_o,lo_o} <= {hi_o,lo_o} - {hi_in,lo_in}, modulo 2^(2*DATA_W).
- PIPE_ACC=0: accumulate commits at the accept edge, same as a write; state stays IDLE.
- PIPE_ACC=1, states IDLE -> ACC_LO -> ACC_HI -> IDLE:
  - Accept edge: latch operand and op, go to ACC_LO.
  - ACC_LO edge: compute lo_o ± lo operand into lo_stage with carry/borrow bit; go to ACC_HI.
  - ACC_HI edge: hi_o <= hi_o ± hi operand ± carry/borrow; lo_o <= lo_stage atomically; go to IDLE.
  - hi_o/lo_o never expose a partial result: both change on the same edge, two edges after accept.
  - done_o=1 in the cycle after the ACC_HI edge; ready_o returns to 1 in that same cycle.
- Operand hold: requests are not accepted while busy; hi_in/lo_in are don't-care after accept, since operands are latched.
- flush_i=1 in ACC_LO or ACC_HI: at the next edge return to IDLE, no commit, hi_o/lo_o unchanged, done_o=0.
- flush_i=1 in IDLE: the request is not accepted because ready_o=0; registers unchanged.
- NOP, invalid ops, or valid_i=0: no change, done_o=0.
- Back-to-back: a new request may be accepted in the cycle done_o is high.

Test Plan:
- Reset: drive rst=1 with valid_i=1, op=WR_BOTH, hi_in=0x1234, lo_in=0x5678 -> hi_o=lo_o=0, done_o=0, ready_o=1 after rst drops.
- Partial writes: WR_BOTH 0xAAAAAAAA/0x55555555, then WR_HI 0x11111111, then WR_LO 0x22222222 -> hi=0x11111111, lo=0x22222222; each value visible one cycle after accept; done_o pulses 3 times.
- MADD carry, PIPE_ACC=1: from hi=0, lo=0xFFFFFFFF, MADD 0x00000000/0x00000001 -> ready_o=0 for 2 cycles, lo_o unchanged until the ACC_HI edge, then hi=0x00000001, lo=0x00000000, done_o=1.
- MSUB wrap: from hi=lo=0, MSUB 0/1 -> hi=lo=0xFFFFFFFF. Then MADD 0/1 -> hi=lo=0 (modulo wrap).
- Flush and reset mid-operation:
  - From hi=5, lo=7, MADD 1/1 with flush_i pulsed in ACC_HI -> hi=5, lo=7, no done_o, IDLE next cycle.
  - Repeat with rst in ACC_LO -> all zero.
- PIPE_ACC=0 and back-to-back: two MADD 0/3 on consecutive cycles from zero -> lo=3 then lo=6 on consecutive cycles, ready_o constant 1.

Source files
------------

// File: rtl/hilo_acc.sv
// HI/LO special registers: writes commit at the accept edge; MADD/MSUB commit atomically 2 edges after accept (PIPE_ACC=1) or at accept (PIPE_ACC=0).
// ready_o drops while an accumulate is in flight or flush_i is high; done_o pulses the cycle after every commit.
module hilo_acc #(
    parameter int DATA_W   = 32,
    parameter int PIPE_ACC = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_i,
    input  logic [2:0]        op_i,
    input  logic [DATA_W-1:0] hi_in,
    input  logic [DATA_W-1:0] lo_in,
    input  logic              flush_i,
    output logic              ready_o,
    output logic              busy_o,
    output logic              done_o,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o
);

    localparam logic [2:0] OP_WR_HI   = 3'd1;
    localparam logic [2:0] OP_WR_LO   = 3'd2;
    localparam logic [2:0] OP_WR_BOTH = 3'd3;
    localparam logic [2:0] OP_MADD    = 3'd4;
    localparam logic [2:0] OP_MSUB    = 3'd5;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACC_LO = 2'd1,
        S_ACC_HI = 2'd2
    } state_t;

    typedef struct packed {
        logic              sub;
        logic [DATA_W-1:0] hi;
        logic [DATA_W-1:0] lo;
    } opnd_t;

    state_t              r_state;
    state_t              w_state_nxt;
    opnd_t               r_opnd;
    logic [DATA_W-1:0]   r_hi;
    logic [DATA_W-1:0]   r_lo;
    logic [DATA_W-1:0]   r_lo_stage;
    logic                r_carry;
    logic                r_done;

    logic                w_accept;
    logic                w_latch;
    logic                w_hi_we;
    logic                w_lo_we;
    logic [DATA_W-1:0]   w_hi_nxt;
    logic [DATA_W-1:0]   w_lo_nxt;
    logic [2*DATA_W-1:0] w_full;
    logic [DATA_W:0]     w_lo_step;
    logic [DATA_W-1:0]   w_hi_step;
    logic [DATA_W-1:0]   w_carry_ext;

    assign ready_o  = (r_state == S_IDLE) & ~flush_i;
    assign busy_o   = (r_state != S_IDLE);
    assign w_accept = valid_i & ready_o;

    assign w_full = (op_i == OP_MSUB) ? ({r_hi, r_lo} - {hi_in, lo_in})
                                      : ({r_hi, r_lo} + {hi_in, lo_in});

    // Split path: MSB of the low-half step is the carry (add) or borrow (sub).
    assign w_lo_step   = r_opnd.sub ? ({1'b0, r_lo} - {1'b0, r_opnd.lo})
                                    : ({1'b0, r_lo} + {1'b0, r_opnd.lo});
    assign w_carry_ext = {{(DATA_W-1){1'b0}}, r_carry};
    assign w_hi_step   = r_opnd.sub ? (r_hi - r_opnd.hi - w_carry_ext)
                                    : (r_hi + r_opnd.hi + w_carry_ext);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_latch     = 1'b0;
        w_hi_we     = 1'b0;
        w_lo_we     = 1'b0;
        w_hi_nxt    = r_hi;
        w_lo_nxt    = r_lo;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    case (op_i)
                        OP_WR_HI: begin
                            w_hi_we  = 1'b1;
                            w_hi_nxt = hi_in;
                        end
                        OP_WR_LO: begin
                            w_lo_we  = 1'b1;
                            w_lo_nxt = lo_in;
                        end
                        OP_WR_BOTH: begin
                            w_hi_we  = 1'b1;
                            w_lo_we  = 1'b1;
                            w_hi_nxt = hi_in;
                            w_lo_nxt = lo_in;
                        end
                        OP_MADD, OP_MSUB: begin
                            if (PIPE_ACC != 0) begin
                                w_latch     = 1'b1;
                                w_state_nxt = S_ACC_LO;
                            end else begin
                                w_hi_we  = 1'b1;
                                w_lo_we  = 1'b1;
                                w_hi_nxt = w_full[2*DATA_W-1:DATA_W];
                                w_lo_nxt = w_full[DATA_W-1:0];
                            end
                        end
                        default: ;
                    endcase
                end
            end
            S_ACC_LO: begin
                w_state_nxt = flush_i ? S_IDLE : S_ACC_HI;
            end
            S_ACC_HI: begin
                w_state_nxt = S_IDLE;
                if (!flush_i) begin
                    w_hi_we  = 1'b1;
                    w_lo_we  = 1'b1;
                    w_hi_nxt = w_hi_step;
                    w_lo_nxt = r_lo_stage;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hi       <= '0;
            r_lo       <= '0;
            r_opnd     <= '0;
            r_lo_stage <= '0;
            r_carry    <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            if (w_hi_we) r_hi <= w_hi_nxt;
            if (w_lo_we) r_lo <= w_lo_nxt;
            if (w_latch) begin
                r_opnd.sub <= (op_i == OP_MSUB);
                r_opnd.hi  <= hi_in;
                r_opnd.lo  <= lo_in;
            end
            if (r_state == S_ACC_LO) begin
                {r_carry, r_lo_stage} <= w_lo_step;
            end
            r_done <= w_hi_we | w_lo_we;
        end
    end

    assign hi_o   = r_hi;
    assign lo_o   = r_lo;
    assign done_o = r_done;

endmodule

// File: tb/tb_hilo_acc.sv
// Bench for hilo_acc: directed vector tables on a pipelined and a single-cycle instance, then random traffic against a reference model.
module tb_hilo_acc;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_v, a_f, b_v, b_f;
    logic [2:0]  a_op, b_op;
    logic [31:0] a_hi, a_lo, b_hi, b_lo;
    logic        a_rdy, a_busy, a_done, b_rdy, b_busy, b_done;
    logic [31:0] a_hi_o, a_lo_o, b_hi_o, b_lo_o;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    hilo_acc #(.DATA_W(32), .PIPE_ACC(1)) dut_a (
        .clk(clk), .rst(rst), .valid_i(a_v), .op_i(a_op), .hi_in(a_hi), .lo_in(a_lo),
        .flush_i(a_f), .ready_o(a_rdy), .busy_o(a_busy), .done_o(a_done),
        .hi_o(a_hi_o), .lo_o(a_lo_o)
    );

    hilo_acc #(.DATA_W(32), .PIPE_ACC(0)) dut_b (
        .clk(clk), .rst(rst), .valid_i(b_v), .op_i(b_op), .hi_in(b_hi), .lo_in(b_lo),
        .flush_i(b_f), .ready_o(b_rdy), .busy_o(b_busy), .done_o(b_done),
        .hi_o(b_hi_o), .lo_o(b_lo_o)
    );

    typedef struct {
        logic        rst;
        logic        v;
        logic [2:0]  op;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        f;
        logic        crdy;
        logic        rdy;
        logic [31:0] eh;
        logic [31:0] el;
        logic        ed;
        logic        eb;
    } vec_t;

    vec_t tbl_a[$];
    vec_t tbl_b[$];

    // Reference model: architectural {HI,LO} plus one pending accumulate result and its commit countdown.
    logic [63:0] m_val  [2];
    logic [63:0] m_pend [2];
    int          m_cnt  [2];
    logic        m_done [2];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic add(input vec_t t, input int k);
        if (k == 1) tbl_a.push_back(t);
        else        tbl_b.push_back(t);
    endtask

    function automatic vec_t mk(input logic r, input logic v, input logic [2:0] op,
                                input logic [31:0] hi, input logic [31:0] lo, input logic f,
                                input logic crdy, input logic rdy,
                                input logic [31:0] eh, input logic [31:0] el,
                                input logic ed, input logic eb);
        vec_t t;
        t.rst = r; t.v = v; t.op = op; t.hi = hi; t.lo = lo; t.f = f;
        t.crdy = crdy; t.rdy = rdy; t.eh = eh; t.el = el; t.ed = ed; t.eb = eb;
        return t;
    endfunction

    task automatic drive(input int k, input logic v, input logic [2:0] op,
                         input logic [31:0] hi, input logic [31:0] lo, input logic f);
        if (k == 1) begin
            a_v = v; a_op = op; a_hi = hi; a_lo = lo; a_f = f;
        end else begin
            b_v = v; b_op = op; b_hi = hi; b_lo = lo; b_f = f;
        end
    endtask

    task automatic run_vec(input int k, input vec_t t, input int idx);
        string tag;
        tag = (k == 1) ? "pipe" : "comb";
        drive(1, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
        drive(0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
        drive(k, t.v, t.op, t.hi, t.lo, t.f);
        rst = t.rst;
        #1;
        if (t.crdy) chk($sformatf("%s[%0d].ready", tag, idx), (k == 1) ? a_rdy : b_rdy, t.rdy);
        @(posedge clk);
        #1;
        chk($sformatf("%s[%0d].hi", tag, idx),   (k == 1) ? a_hi_o : b_hi_o, t.eh);
        chk($sformatf("%s[%0d].lo", tag, idx),   (k == 1) ? a_lo_o : b_lo_o, t.el);
        chk($sformatf("%s[%0d].done", tag, idx), (k == 1) ? a_done : b_done, t.ed);
        chk($sformatf("%s[%0d].busy", tag, idx), (k == 1) ? a_busy : b_busy, t.eb);
    endtask

    task automatic model_step(input int k, input logic r, input logic v, input logic [2:0] op,
                              input logic [31:0] hi, input logic [31:0] lo, input logic f);
        logic [63:0] res;
        m_done[k] = 1'b0;
        if (r) begin
            m_val[k] = 64'd0;
            m_cnt[k] = 0;
        end else if (m_cnt[k] > 0) begin
            if (f) begin
                m_cnt[k] = 0;
            end else begin
                m_cnt[k]--;
                if (m_cnt[k] == 0) begin
                    m_val[k]  = m_pend[k];
                    m_done[k] = 1'b1;
                end
            end
        end else if (v && !f) begin
            case (op)
                3'd1: begin m_val[k][63:32] = hi; m_done[k] = 1'b1; end
                3'd2: begin m_val[k][31:0]  = lo; m_done[k] = 1'b1; end
                3'd3: begin m_val[k] = {hi, lo}; m_done[k] = 1'b1; end
                3'd4, 3'd5: begin
                    res = (op == 3'd4) ? m_val[k] + {hi, lo} : m_val[k] - {hi, lo};
                    if (k == 1) begin
                        m_pend[k] = res;
                        m_cnt[k]  = 2;
                    end else begin
                        m_val[k]  = res;
                        m_done[k] = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    endtask

    function automatic logic [31:0] rnd_word();
        case ($urandom_range(0, 3))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'($urandom_range(0, 3));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        logic        r;
        logic [2:0]  op;
        logic [31:0] hi, lo;
        logic        v, f;

        rst = 1'b1;
        drive(1, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
        drive(0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0);

        //         rst  v    op    hi             lo             f    crdy rdy  exp_hi         exp_lo         done busy
        // reset dominates a valid write
        add(mk(1'b1,1'b1,3'd3,32'h1234,      32'h5678,      1'b0,1'b0,1'b0,32'h0,         32'h0,         1'b0,1'b0), 1);
        add(mk(1'b1,1'b1,3'd3,32'h1234,      32'h5678,      1'b0,1'b0,1'b0,32'h0,         32'h0,         1'b0,1'b0), 1);
        add(mk(1'b0,1'b0,3'd0,32'h0,         32'h0,         1'b0,1'b1,1'b1,32'h0,         32'h0,         1'b0,1'b0), 1);
        // partial writes
        add(mk(1'b0,1'b1,3'd3,32'hAAAAAAAA,  32'h55555555,  1'b0,1'b1,1'b1,32'hAAAAAAAA,  32'h55555555,  1'b1,1'b0), 1);
        add(mk(1'b0,1'b1,3'd1,32'h11111111,  32'hDEADBEEF,  1'b0,1'b1,1'b1,32'h11111111,  32'h55555555,  1'b1,1'b0), 1);
        add(mk(1'b0,1'b1,3'd2,32'hCAFEF00D,  32'h22222222,  1'b0,1'b1,1'b1,32'h11111111,  32'h22222222,  1'b1,1'b0), 1);
        add(mk(1'b0,1'b0,3'd3,32'h0,         32'h0,         1'b0,1'b1,1'b1,32'h11111111,  32'h22222222,  1'b0,1'b0), 1);
        // MADD carry from LO into HI; the request during busy is dropped
        add(mk(1'b0,1'b1,3'd3,32'h0,         32'hFFFFFFFF,  1'b0,1'b1,1'b1,32'h0,         32'hFFFFFFFF,  1'b1,1'b0), 1);
        add(mk(1'b0,1'b1,3'd4,32'h0,         32'h1,         1'b0,1'b1,1'b1,32'h0,         32'hFFFFFFFF,  1'b0,1'b1), 1);
        add(mk(1'b0,1'b1,3'd3,32'h9,         32'h9,         1'b0,1'b1,1'b0,32'h0,         32'hFFFFFFFF,  1'b0,1'b1), 1);
        add(mk(1'b0,1'b0,3'd0,32'h0,         32'h0,         1'b0,1'b1,1'b0,32'h1,         32'h0,         1'b1,1'b0), 1);
        // back-to-back in the done cycle, MSUB wrap, MADD wrap back to zero
        add(mk(1'b0,1'b1,3'd3,32'h0,         32'h0,         1'b0,1'b1,1'b1,32'h0,         32'h0,         1'b1,1'b0), 1);
        add(mk(1'b0,1'b1,3'd5,32'h0,         32'h1,         1'b0,1'b1,1'b1,32'h0,         32'h0,         1'b0,1'b1), 1);
        add(mk(1'b0,1'b0,3'd0,32'h0,         32'h0,         1'b0,1'b1,1'b0,32'h0,         32'h0,         1'b0,1'b1), 1);
        add(mk(1'b0,1'b0,3'd0,32'h0,         32'h0,         1'b0,1'b1,1'b0,32'hFFFFFFFF,  32'hFFFFFFFF,  1'b1,1'b0), 1);
        add(mk(1'b0,1'b1,3'd4,32'h0,         32'h1,         1'b0,1'b1,1'b1,32'hFFFFFFFF,  32'hFFFFFFFF,  1'b0,1'b1), 1);
        add(mk(1'b0,1'b0,3'd0,32'h0,         32'h0,         1'b0,1'b1,1'b0,32'hFFFFFFFF,  32'hFFFFFFFF,  1'b0,1'b1), 1);
        add(mk(1'b0,1'b0,3'd0,32'h0,         32'h0,         1'b0,1'b1,1'b0,32'h0,         32'h0,         1'b1,1'b0), 1);
        // flush in ACC_HI, then flush while idle blocks a request
        add(mk(1'b0,1'b1,3'd3,32'h5,         32'h7,         1'b0,1'b1,1'b1,32'h5,         32'h7,         1'b1,1'b0), 1);
        add(mk(1'b0,1'b1,3'd4,32'h1,         32'h1,         1'b0,1'b1,1'b1,32'h5,         32'h7,         1'b0,1'b1), 1);
        add(mk(1'b0,1'b0,3'd0,32'h0,         32'h0,         1'b0,1'b1,1'b0,32'h5,         32'h7,         1'b0,1'b1), 1);
        add(mk(1'b0,1'b0,3'd0,32'h0,         32'h0,         1'b1,1'b1,1'b0,32'h5,         32'h7,         1'b0,1'b0), 1);
        add(mk(1'b0,1'b0,3'd0,32'h0,         32'h0,         1'b0,1'b1,1'b1,32'h5,         32'h7,         1'b0,1'b0), 1);
        add(mk(1'b0,1'b1,3'd3,32'h1,         32'h1,         1'b1,1'b1,1'b0,32'h5,         32'h7,         1'b0,1'b0), 1);
        // reset in ACC_LO
        add(mk(1'b0,1'b1,3'd4,32'h1,         32'h1,         1'b0,1'b1,1'b1,32'h5,         32'h7,         1'b0,1'b1), 1);
        add(mk(1'b1,1'b0,3'd0,32'h0,         32'h0,         1'b0,1'b1,1'b0,32'h0,         32'h0,         1'b0,1'b0), 1);
        add(mk(1'b0,1'b0,3'd0,32'h0,         32'h0,         1'b0,1'b1,1'b1,32'h0,         32'h0,         1'b0,1'b0), 1);
        // flush in ACC_LO, invalid op and NOP
        add(mk(1'b0,1'b1,3'd3,32'h5,         32'h7,         1'b0,1'b1,1'b1,32'h5,         32'h7,         1'b1,1'b0), 1);
        add(mk(1'b0,1'b1,3'd5,32'h1,         32'h1,         1'b0,1'b1,1'b1,32'h5,         32'h7,         1'b0,1'b1), 1);
        add(mk(1'b0,1'b0,3'd0,32'h0,         32'h0,         1'b1,1'b1,1'b0,32'h5,         32'h7,         1'b0,1'b0), 1);
        add(mk(1'b0,1'b1,3'd6,32'h9,         32'h9,         1'b0,1'b1,1'b1,32'h5,         32'h7,         1'b0,1'b0), 1);
        add(mk(1'b0,1'b1,3'd0,32'h9,         32'h9,         1'b0,1'b1,1'b1,32'h5,         32'h7,         1'b0,1'b0), 1);
        // MADD without carry, then MSUB with borrow into HI
        add(mk(1'b0,1'b1,3'd4,32'h10,        32'h8,         1'b0,1'b1,1'b1,32'h5,         32'h7,         1'b0,1'b1), 1);
        add(mk(1'b0,1'b0,3'd0,32'h0,         32'h0,         1'b0,1'b1,1'b0,32'h5,         32'h7,         1'b0,1'b1), 1);
        add(mk(1'b0,1'b0,3'd0,32'h0,         32'h0,         1'b0,1'b1,1'b0,32'h15,        32'hF,         1'b1,1'b0), 1);
        add(mk(1'b0,1'b1,3'd5,32'h5,         32'h10,        1'b0,1'b1,1'b1,32'h15,        32'hF,         1'b0,1'b1), 1);
        add(mk(1'b0,1'b0,3'd0,32'h0,         32'h0,         1'b0,1'b1,1'b0,32'h15,        32'hF,         1'b0,1'b1), 1);
        add(mk(1'b0,1'b0,3'd0,32'h0,         32'h0,         1'b0,1'b1,1'b0,32'hF,         32'hFFFFFFFF,  1'b1,1'b0), 1);

        // single-cycle instance, zeroed by the shared reset above
        add(mk(1'b0,1'b1,3'd4,32'h0,         32'h3,         1'b0,1'b1,1'b1,32'h0,         32'h3,         1'b1,1'b0), 0);
        add(mk(1'b0,1'b1,3'd4,32'h0,         32'h3,         1'b0,1'b1,1'b1,32'h0,         32'h6,         1'b1,1'b0), 0);
        add(mk(1'b0,1'b1,3'd5,32'h0,         32'h7,         1'b0,1'b1,1'b1,32'hFFFFFFFF,  32'hFFFFFFFF,  1'b1,1'b0), 0);
        add(mk(1'b0,1'b1,3'd4,32'h0,         32'h1,         1'b0,1'b1,1'b1,32'h0,         32'h0,         1'b1,1'b0), 0);
        add(mk(1'b0,1'b1,3'd4,32'h0,         32'h1,         1'b1,1'b1,1'b0,32'h0,         32'h0,         1'b0,1'b0), 0);
        add(mk(1'b0,1'b0,3'd0,32'h0,         32'h0,         1'b0,1'b1,1'b1,32'h0,         32'h0,         1'b0,1'b0), 0);

        @(posedge clk);
        #1;
        foreach (tbl_a[i]) run_vec(1, tbl_a[i], i);
        foreach (tbl_b[i]) run_vec(0, tbl_b[i], i);

        for (int i = 0; i < 400; i++) begin
            r = (i == 0) || ($urandom_range(0, 49) == 0);
            for (int k = 0; k < 2; k++) begin
                v  = ($urandom_range(0, 3) != 0);
                op = 3'($urandom_range(0, 7));
                hi = rnd_word();
                lo = rnd_word();
                f  = ($urandom_range(0, 5) == 0);
                drive(k, v, op, hi, lo, f);
            end
            rst = r;
            #1;
            if (i != 0) begin
                chk($sformatf("rnd[%0d].pipe.ready", i), a_rdy, (m_cnt[1] == 0) && !a_f);
                chk($sformatf("rnd[%0d].comb.ready", i), b_rdy, (m_cnt[0] == 0) && !b_f);
            end
            model_step(1, r, a_v, a_op, a_hi, a_lo, a_f);
            model_step(0, r, b_v, b_op, b_hi, b_lo, b_f);
            @(posedge clk);
            #1;
            chk($sformatf("rnd[%0d].pipe.hilo", i), {a_hi_o, a_lo_o}, m_val[1]);
            chk($sformatf("rnd[%0d].pipe.done", i), a_done, m_done[1]);
            chk($sformatf("rnd[%0d].pipe.busy", i), a_busy, m_cnt[1] > 0);
            chk($sformatf("rnd[%0d].comb.hilo", i), {b_hi_o, b_lo_o}, m_val[0]);
            chk($sformatf("rnd[%0d].comb.done", i), b_done, m_done[0]);
            chk($sformatf("rnd[%0d].comb.busy", i), b_busy, m_cnt[0] > 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
